// File: rtl/eth_rx_pkg.sv
// Shared GMII receive types, constants and the byte-wide CRC-32 step.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Registered reflected CRC-32, one byte per enabled cycle.
// init has priority over en.
module eth_crc32_byte
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/eth_gmii_frame_rx.sv
// GMII receive front end: preamble/SFD delineation, byte stream,
// CRC and length checks, saturating good/bad frame counters.
module eth_gmii_frame_rx
  import eth_rx_pkg::*;
#(
  parameter int PRE_MIN   = 7,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int STRIP_FCS = 1,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk_125m,
  input  logic             rst_n,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  input  logic             cnt_clr,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic             frame_done,
  output logic             frame_good,
  output logic             err_crc,
  output logic             err_short,
  output logic             err_long,
  output logic             err_phy,
  output logic             err_pre,
  output logic [LEN_W-1:0] frame_length,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad
);

  localparam int D  = (STRIP_FCS != 0) ? 5 : 1;
  localparam int FW = $clog2(D + 1);
  localparam int PW = $clog2(PRE_MIN + 1) + 1;

  localparam logic [FW-1:0]    FULL    = FW'(D);
  localparam logic [PW-1:0]    PRE_OK  = PW'(PRE_MIN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  rx_state_e        state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             sof_q, sof_d;
  logic             phy_q, phy_d;
  logic [7:0]       dl_q [D];

  logic        shift, crc_init, crc_en;
  logic        emit, fin, pre_err, done;
  logic        crc_bad, too_short, too_long, bad;
  logic [31:0] crc;

  eth_crc32_byte u_crc (
    .clk   (clk_125m),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (rxd),
    .crc   (crc)
  );

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      sof_q   <= 1'b0;
      phy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      sof_q   <= sof_d;
      phy_q   <= phy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    len_d    = len_q;
    fill_d   = fill_q;
    sof_d    = sof_q;
    phy_d    = phy_q;
    shift    = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    emit     = 1'b0;
    fin      = 1'b0;
    pre_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        crc_init = 1'b1;
        if (rx_dv) begin
          state_d = PRE;
          pre_d   = PW'(1);
        end
      end
      PRE: begin
        crc_init = 1'b1;
        if (!rx_dv) begin
          pre_err = 1'b1;
          state_d = IDLE;
        end else if (rxd == ETH_PREAMBLE) begin
          if (pre_q != '1) pre_d = pre_q + PW'(1);
        end else if (rxd == ETH_SFD && pre_q >= PRE_OK) begin
          state_d = DATA;
          len_d   = '0;
          fill_d  = '0;
          sof_d   = 1'b1;
          phy_d   = 1'b0;
        end else begin
          pre_err = 1'b1;
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          crc_en = 1'b1;
          shift  = 1'b1;
          if (len_q != '1) len_d = len_q + LEN_W'(1);
          if (rx_er) phy_d = 1'b1;
          if (fill_q == FULL) begin
            emit  = 1'b1;
            sof_d = 1'b0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end else begin
          // Oldest held byte closes the stream; the rest is FCS.
          fin     = 1'b1;
          emit    = (fill_q == FULL);
          fill_d  = '0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = pre_err | fin;
  assign crc_bad   = (crc != CRC32_RESIDUE);
  assign too_short = (len_q < LEN_MIN);
  assign too_long  = (len_q > LEN_MAX);
  assign bad       = crc_bad | too_short | too_long | phy_q;

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) dl_q[i] <= '0;
    end else if (shift) begin
      dl_q[0] <= rxd;
      for (int i = 1; i < D; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_sof        <= 1'b0;
      m_eof        <= 1'b0;
      frame_done   <= 1'b0;
      frame_good   <= 1'b0;
      err_crc      <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_phy      <= 1'b0;
      err_pre      <= 1'b0;
      frame_length <= '0;
    end else begin
      m_data       <= emit ? dl_q[D-1] : 8'h00;
      m_valid      <= emit;
      m_sof        <= emit & sof_q;
      m_eof        <= emit & fin;
      frame_done   <= done;
      frame_good   <= fin & ~bad;
      err_crc      <= fin & crc_bad;
      err_short    <= fin & too_short;
      err_long     <= fin & too_long;
      err_phy      <= fin & phy_q;
      err_pre      <= pre_err;
      frame_length <= fin ? len_q : '0;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else if (cnt_clr) begin
      cnt_good <= '0;
      cnt_bad  <= '0;
    end else if (frame_done) begin
      if (frame_good) begin
        if (cnt_good != '1) cnt_good <= cnt_good + CNT_W'(1);
      end else begin
        if (cnt_bad != '1) cnt_bad <= cnt_bad + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_eth_gmii_frame_rx.sv
// Directed bench for eth_gmii_frame_rx: FCS-stripping and
// FCS-passing builds share the same GMII stimulus.
module tb_eth_gmii_frame_rx;

  logic       clk_125m = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_dv    = 1'b0;
  logic       rx_er    = 1'b0;
  logic       cnt_clr  = 1'b0;
  logic [7:0] rxd      = 8'h00;

  logic [7:0]  a_data, b_data;
  logic        a_valid, a_sof, a_eof, a_done, a_good;
  logic        a_ecrc, a_eshort, a_elong, a_ephy, a_epre;
  logic        b_valid, b_sof, b_eof, b_done, b_good;
  logic        b_ecrc, b_eshort, b_elong, b_ephy, b_epre;
  logic [15:0] a_len, b_len;
  logic [31:0] a_cg, a_cb, b_cg, b_cb;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  tx_q [$];
  logic [31:0] exp_fcs;

  logic [7:0]  ca_q [$];
  logic [7:0]  cb_q [$];
  int          ca_sof_n, ca_sof_i, ca_eof_n, ca_eof_i, ca_done;
  int          cb_eof_n, cb_eof_i, cb_done;
  logic        ca_good, ca_crc, ca_short, ca_long, ca_phy, ca_pre;
  logic        cb_pre;
  logic [15:0] ca_len;

  always #4 clk_125m = ~clk_125m;

  eth_gmii_frame_rx dut (
    .clk_125m(clk_125m), .rst_n(rst_n), .rx_dv(rx_dv),
    .rx_er(rx_er), .rxd(rxd), .cnt_clr(cnt_clr),
    .m_data(a_data), .m_valid(a_valid), .m_sof(a_sof),
    .m_eof(a_eof), .frame_done(a_done), .frame_good(a_good),
    .err_crc(a_ecrc), .err_short(a_eshort), .err_long(a_elong),
    .err_phy(a_ephy), .err_pre(a_epre), .frame_length(a_len),
    .cnt_good(a_cg), .cnt_bad(a_cb)
  );

  eth_gmii_frame_rx #(.STRIP_FCS(0)) dut_fcs (
    .clk_125m(clk_125m), .rst_n(rst_n), .rx_dv(rx_dv),
    .rx_er(rx_er), .rxd(rxd), .cnt_clr(cnt_clr),
    .m_data(b_data), .m_valid(b_valid), .m_sof(b_sof),
    .m_eof(b_eof), .frame_done(b_done), .frame_good(b_good),
    .err_crc(b_ecrc), .err_short(b_eshort), .err_long(b_elong),
    .err_phy(b_ephy), .err_pre(b_epre), .frame_length(b_len),
    .cnt_good(b_cg), .cnt_bad(b_cb)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build(input int plen, input bit bad_fcs,
                       input int bad_pre, input int npre);
    logic [31:0] c;
    tx_q.delete();
    for (int i = 0; i < npre; i++)
      tx_q.push_back(i == bad_pre ? 8'hAA : 8'h55);
    tx_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      c = crc_upd(c, 8'(i));
      tx_q.push_back(8'(i));
    end
    exp_fcs = ~c;
    for (int k = 0; k < 4; k++) tx_q.push_back(exp_fcs[8*k +: 8]);
    if (bad_fcs) tx_q[npre + plen] = tx_q[npre + plen] ^ 8'hFF;
  endtask

  task automatic clr_cap();
    ca_q.delete();
    cb_q.delete();
    ca_sof_n = 0; ca_sof_i = -1; ca_eof_n = 0; ca_eof_i = -1;
    ca_done = 0; cb_eof_n = 0; cb_eof_i = -1; cb_done = 0;
    ca_good = 0; ca_crc = 0; ca_short = 0; ca_long = 0;
    ca_phy = 0; ca_pre = 0; ca_len = 0; cb_pre = 0;
  endtask

  task automatic mon();
    forever begin
      @(negedge clk_125m);
      if (a_valid) begin
        ca_q.push_back(a_data);
        if (a_sof) begin ca_sof_n++; ca_sof_i = ca_q.size() - 1; end
        if (a_eof) begin ca_eof_n++; ca_eof_i = ca_q.size() - 1; end
      end
      if (a_done) begin
        ca_done++;
        ca_good = a_good; ca_crc = a_ecrc; ca_short = a_eshort;
        ca_long = a_elong; ca_phy = a_ephy; ca_pre = a_epre;
        ca_len = a_len;
      end
      if (b_valid) begin
        cb_q.push_back(b_data);
        if (b_eof) begin cb_eof_n++; cb_eof_i = cb_q.size() - 1; end
      end
      if (b_done) begin
        cb_done++;
        cb_pre = b_epre;
      end
    end
  endtask

  task automatic drive(input int er_idx);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge clk_125m); #1;
      rx_dv = 1'b1;
      rxd   = tx_q[i];
      rx_er = (i == er_idx);
    end
    @(posedge clk_125m); #1;
    rx_dv = 1'b0; rxd = 8'h00; rx_er = 1'b0;
    repeat (6) @(posedge clk_125m);
    #1;
  endtask

  task automatic chk_data(input string tag);
    int bad = 0;
    for (int i = 0; i < ca_q.size(); i++)
      if (ca_q[i] !== 8'(i)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic chk_stat(input string t, input int len,
                          input bit good, input bit crc,
                          input bit sh, input bit lg,
                          input bit phy);
    chk({t, "_done"}, ca_done, 1);
    chk({t, "_len"}, ca_len, len);
    chk({t, "_good"}, ca_good, good);
    chk({t, "_crc"}, ca_crc, crc);
    chk({t, "_short"}, ca_short, sh);
    chk({t, "_long"}, ca_long, lg);
    chk({t, "_phy"}, ca_phy, phy);
    chk({t, "_pre"}, ca_pre, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    clr_cap();
    fork mon(); join_none
    repeat (3) @(posedge clk_125m);
    #1 rst_n = 1'b1;
    @(negedge clk_125m);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_done", a_done, 0);
    chk("rst_len", a_len, 0);
    chk("rst_cg", a_cg, 0);
    chk("rst_cb", a_cb, 0);

    // good 64-byte frame
    clr_cap(); build(60, 0, -1, 7); drive(-1);
    chk("t1_n", ca_q.size(), 60);
    chk_data("t1_data");
    chk("t1_sof_n", ca_sof_n, 1);
    chk("t1_sof_i", ca_sof_i, 0);
    chk("t1_eof_n", ca_eof_n, 1);
    chk("t1_eof_i", ca_eof_i, 59);
    chk_stat("t1", 64, 1, 0, 0, 0, 0);
    chk("t1_cg", a_cg, 1);
    chk("t1_cb", a_cb, 0);
    chk("t1_b_n", cb_q.size(), 64);
    chk("t1_b_eof_i", cb_eof_i, 63);
    chk("t1_b_last", cb_q.size() == 64 ? cb_q[63] : 8'h00,
        exp_fcs[31:24]);

    // corrupted last payload byte
    clr_cap(); build(60, 1, -1, 7); drive(-1);
    chk("t2_n", ca_q.size(), 60);
    chk_stat("t2", 64, 0, 1, 0, 0, 0);
    chk("t2_cb", a_cb, 1);
    chk("t2_cg", a_cg, 1);

    // bad preamble byte, then recovery
    clr_cap(); build(60, 0, 2, 7); drive(-1);
    chk("t3_done", ca_done, 1);
    chk("t3_pre", ca_pre, 1);
    chk("t3_good", ca_good, 0);
    chk("t3_n", ca_q.size(), 0);
    chk("t3_b_n", cb_q.size(), 0);
    chk("t3_b_pre", cb_pre, 1);
    clr_cap(); build(60, 0, -1, 6); drive(-1);
    chk("t3_few_done", ca_done, 1);
    chk("t3_few_pre", ca_pre, 1);
    chk("t3_few_n", ca_q.size(), 0);
    clr_cap(); build(60, 0, -1, 7); drive(-1);
    chk("t3_rec_n", ca_q.size(), 60);
    chk_stat("t3_rec", 64, 1, 0, 0, 0, 0);
    chk("t3_cg", a_cg, 2);
    chk("t3_cb", a_cb, 3);

    // length boundaries
    clr_cap(); build(46, 0, -1, 7); drive(-1);
    chk_stat("t4s", 50, 0, 0, 1, 0, 0);
    chk("t4s_n", ca_q.size(), 46);
    clr_cap(); build(1515, 0, -1, 7); drive(-1);
    chk_stat("t4l", 1519, 0, 0, 0, 1, 0);
    chk("t4l_n", ca_q.size(), 1515);
    clr_cap(); build(1514, 0, -1, 7); drive(-1);
    chk_stat("t4m", 1518, 1, 0, 0, 0, 0);
    chk("t4_cg", a_cg, 3);
    chk("t4_cb", a_cb, 5);

    // rx_er mid-payload, CRC still correct
    clr_cap(); build(508, 0, -1, 7); drive(8 + 200);
    chk_stat("t5", 512, 0, 0, 0, 0, 1);
    chk("t5_cb", a_cb, 6);

    // reset in the middle of a frame
    build(60, 0, -1, 7);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge clk_125m); #1;
      rx_dv = 1'b1; rxd = tx_q[i];
      if (i == 30) begin clr_cap(); rst_n = 1'b0; end
      if (i == 34) rst_n = 1'b1;
      if (i == 31) begin
        @(negedge clk_125m);
        chk("t6_rst_valid", a_valid, 0);
        chk("t6_rst_done", a_done, 0);
        chk("t6_rst_cb", a_cb, 0);
        chk("t6_rst_b_valid", b_valid, 0);
      end
    end
    @(posedge clk_125m); #1;
    rx_dv = 1'b0; rxd = 8'h00;
    repeat (6) @(posedge clk_125m);
    #1;
    chk("t6_done", ca_done, 1);
    chk("t6_pre", ca_pre, 1);
    chk("t6_n", ca_q.size(), 0);
    chk("t6_eof_n", ca_eof_n, 0);
    chk("t6_b_done", cb_done, 1);
    chk("t6_cg", a_cg, 0);
    chk("t6_cb", a_cb, 1);

    // cnt_clr in the same cycle as frame_done
    clr_cap(); build(60, 0, -1, 7);
    seen = 1'b0;
    fork
      drive(-1);
      begin
        for (int k = 0; k < 300; k++) begin
          @(negedge clk_125m);
          if (a_done) begin seen = 1'b1; break; end
        end
        if (seen) begin
          cnt_clr = 1'b1;
          @(posedge clk_125m); #1;
          cnt_clr = 1'b0;
        end
      end
    join
    chk("t7_seen", seen, 1);
    chk("t7_good", ca_good, 1);
    chk("t7_cg", a_cg, 0);
    chk("t7_cb", a_cb, 0);
    chk("t7_b_cg", b_cg, 0);
    chk("t7_b_cb", b_cb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
